// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 WIDTH-bit mux between four requesters,
// feeding a one-entry valid/ready output register (1 word/cycle when drained).
module mux4x1_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       req_i,
    input  logic [WIDTH-1:0] A0_i,
    input  logic [WIDTH-1:0] A1_i,
    input  logic [WIDTH-1:0] A2_i,
    input  logic [WIDTH-1:0] A3_i,
    output logic [3:0]       ack_o,
    output logic             S0_o,
    output logic             S1_o,
    output logic [WIDTH-1:0] Y_o,
    output logic             valid_o,
    input  logic             ready_i
);
    typedef enum logic {EMPTY, FULL} out_state_e;

    out_state_e              state;
    logic [1:0]              ptr;
    logic [1:0]              win;
    logic [3:0][WIDTH-1:0]   din;
    logic                    can_load;
    logic                    load;

    assign din = {A3_i, A2_i, A1_i, A0_i};

    // Scan from the farthest offset down so the nearest requester after ptr wins;
    // offset 4 wraps to ptr itself, which is also the idle select value.
    always_comb begin
        win = ptr;
        for (int off = 4; off >= 1; off--) begin
            if (req_i[ptr + 2'(off)]) win = ptr + 2'(off);
        end
    end

    assign {S1_o, S0_o} = win;
    assign valid_o      = (state == FULL);
    assign can_load     = ~valid_o | ready_i;
    assign load         = can_load & (|req_i) & ~rst_i;

    for (genvar k = 0; k < 4; k++) begin : g_ack
        assign ack_o[k] = load & (win == 2'(k));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
            Y_o   <= '0;
            ptr   <= 2'd3;
        end else if (load) begin
            state <= FULL;
            Y_o   <= din[win];
            ptr   <= win;
        end else if (ready_i && state == FULL) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Scoreboard bench for mux4x1_rr_arbiter: directed scenarios then randomized
// requesters, checked against a queue-based round-robin reference model.
module tb_mux4x1_rr_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, ready;
    logic [3:0]   req, ack;
    logic [W-1:0] a [4];
    logic [W-1:0] y;
    logic         s0, s1, valid;

    int checks = 0;
    int errors = 0;

    // Reference model state: words sitting in the output register, last grant.
    logic [W-1:0] q [$];
    int           ptr = 3;
    bit           pend_rst = 1'b1;
    bit           pend_load = 1'b0;
    logic [W-1:0] pend_word = '0;
    int           pend_w = 0;
    logic [3:0]   last_ack = '0;

    always #5 clk = ~clk;

    mux4x1_rr_arbiter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .A0_i(a[0]), .A1_i(a[1]), .A2_i(a[2]), .A3_i(a[3]),
        .ack_o(ack), .S0_o(s0), .S1_o(s1),
        .Y_o(y), .valid_o(valid), .ready_i(ready)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus: retire the model effects of the previous edge,
    // drive new inputs, predict the grant and check the combinational outputs.
    task automatic cycle(input bit r, input logic [3:0] rq,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3,
                         input bit rdy);
        int         w;
        bit         found;
        bit         ld;
        logic [3:0] exp_ack;
        @(posedge clk);
        #1;
        if (pend_rst) begin
            q.delete();
            ptr = 3;
            chk("reset_valid", {31'd0, valid}, 32'd0);
            chk("reset_y", {28'd0, y}, 32'd0);
        end else if (pend_load) begin
            q.push_back(pend_word);
            ptr = pend_w;
        end
        rst = r; req = rq; ready = rdy;
        a[0] = d0; a[1] = d1; a[2] = d2; a[3] = d3;
        w = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && rq[(ptr + i) % 4]) begin
                w = (ptr + i) % 4;
                found = 1'b1;
            end
        end
        ld = !r && found && (q.size() == 0 || rdy);
        exp_ack = ld ? 4'(1 << w) : 4'd0;
        pend_rst = r; pend_load = ld; pend_word = a[w]; pend_w = w;
        last_ack = exp_ack;
        #4;
        chk("ack", {28'd0, ack}, {28'd0, exp_ack});
        chk("select", {30'd0, s1, s0}, 32'(w));
    endtask

    // Monitor: consumes the expected word on every completed output handshake.
    initial begin
        logic [W-1:0] exp_y;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                chk("valid", {31'd0, valid}, {31'd0, q.size() != 0});
                if (valid && ready) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %0h expected none", y);
                    end else begin
                        exp_y = q.pop_front();
                        chk("y", {28'd0, y}, {28'd0, exp_y});
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]   nreq;
        logic [W-1:0] nd [4];
        rst = 1'b1; ready = 1'b0; req = '0;
        for (int k = 0; k < 4; k++) a[k] = '0;

        // Reset with all requesting, then round robin 1,2,3,4,1 back-to-back
        cycle(1, 4'b1111, 1, 2, 3, 4, 1);
        cycle(1, 4'b1111, 1, 2, 3, 4, 1);
        repeat (5) cycle(0, 4'b1111, 1, 2, 3, 4, 1);
        repeat (2) cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        // Single request from lane 2
        cycle(0, 4'b0100, 0, 0, 9, 0, 1);
        repeat (2) cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        // Backpressure: hold 5, lane 1 waits, then drain and load 6
        cycle(0, 4'b0001, 5, 0, 0, 0, 1);
        repeat (3) cycle(0, 4'b0010, 0, 6, 0, 0, 0);
        cycle(0, 4'b0010, 0, 6, 0, 0, 1);
        cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        // Skip and wrap from ptr=1: winners 3, 0, 1
        repeat (3) cycle(0, 4'b1011, 7, 8, 0, 10, 1);
        cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        // Reset while stalled with ptr=2
        cycle(0, 4'b0100, 0, 0, 11, 0, 1);
        cycle(0, 4'b0000, 0, 0, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 0, 0, 0);
        cycle(0, 4'b1111, 12, 13, 14, 15, 1);
        cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        // Random requesters that hold their word until acked
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (req[k] && !last_ack[k]) begin
                    nreq[k] = 1'b1;
                    nd[k]   = a[k];
                end else begin
                    nreq[k] = ($urandom_range(0, 99) < 45);
                    nd[k]   = W'($urandom);
                end
            end
            cycle(($urandom_range(0, 99) == 0), nreq, nd[0], nd[1], nd[2], nd[3],
                  ($urandom_range(0, 99) < 70));
        end
        repeat (3) cycle(0, 4'b0000, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
